// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmit frame generator; optional break generation under UART_TX_BREAK_EN
module uart_tx_frame_gen #(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_BITS   = 9,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                brgen_tick,
  input  logic                enable,
  input  logic                empty,
  input  logic [MAX_BITS-1:0] data,
  input  logic [2:0]          size,
  input  logic [1:0]          parity,
  input  logic [1:0]          stop,
  input  logic                brk,
  output logic                data_request,
  output logic                out,
  output logic                busy,
  output logic                tx_done
);

  // Tick counter is wide enough for the longest segment (break minimum of 12 bit times).
  localparam int TW = CNT_W + 4;
  localparam logic [TW-1:0] BIT_T = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] ONE_T = TW'(1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic unused_brk;
  assign unused_brk = brk;
`endif

  state_t                state, state_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [MAX_BITS-1:0]   shift, shift_n;
  logic [3:0]            nbits_q, nbits_n;
  logic [1:0]            par_q, par_n;
  logic [1:0]            stop_q, stop_n;
  logic                  par_bit_q, par_bit_n;
  logic                  brk_stop_q, brk_stop_n;

  logic [3:0]            nbits_dec, nbits_in;
  logic                  data_xor, par_bit_in;
  logic [TW-1:0]         stop_len;
  logic                  launch;

  // Decode the live configuration and precompute the parity bit for a word about to launch.
  always_comb begin
    nbits_dec = (size >= 3'd4) ? 4'd9 : ({1'b0, size} + 4'd5);
    nbits_in  = nbits_dec;
    if (nbits_dec > 4'(MAX_BITS)) nbits_in = 4'(MAX_BITS);
    data_xor = 1'b0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < int'(nbits_in)) data_xor = data_xor ^ data[i];
    end
    case (parity)
      2'b01:   par_bit_in = data_xor;
      2'b10:   par_bit_in = ~data_xor;
      default: par_bit_in = 1'b1;
    endcase
  end

  // Stop segment length from the shadowed setting; the post-break stop is always one bit time.
  always_comb begin
    if (brk_stop_q) begin
      stop_len = BIT_T;
    end else begin
      case (stop_q)
        2'b00:   stop_len = BIT_T;
        2'b01:   stop_len = BIT_T + (BIT_T >> 1);
        default: stop_len = BIT_T << 1;
      endcase
    end
  end

  // Next-state, datapath and output decode; all progress happens only on brgen_tick.
  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    nbits_n      = nbits_q;
    par_n        = par_q;
    stop_n       = stop_q;
    par_bit_n    = par_bit_q;
    brk_stop_n   = brk_stop_q;
    data_request = 1'b0;
    tx_done      = 1'b0;
    out          = 1'b1;
    busy         = 1'b1;
    launch       = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (brgen_tick) begin
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state_n = S_BREAK;
            tcnt_n  = '0;
            nbits_n = nbits_in;
          end else
`endif
          if (enable && !empty) launch = 1'b1;
        end
      end
      S_START: begin
        out = 1'b0;
        if (brgen_tick) begin
          if (tcnt == BIT_T - ONE_T) begin
            state_n   = S_DATA;
            tcnt_n    = '0;
            bit_cnt_n = '0;
          end else begin
            tcnt_n = tcnt + ONE_T;
          end
        end
      end
      S_DATA: begin
        out = shift[0];
        if (brgen_tick) begin
          if (tcnt == BIT_T - ONE_T) begin
            tcnt_n    = '0;
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == nbits_q - 4'd1) state_n = (par_q != 2'b00) ? S_PARITY : S_STOP;
          end else begin
            tcnt_n = tcnt + ONE_T;
          end
        end
      end
      S_PARITY: begin
        out = par_bit_q;
        if (brgen_tick) begin
          if (tcnt == BIT_T - ONE_T) begin
            state_n = S_STOP;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + ONE_T;
          end
        end
      end
      S_STOP: begin
        out = 1'b1;
        if (brgen_tick) begin
          if (tcnt == stop_len - ONE_T) begin
            tcnt_n = '0;
            if (brk_stop_q) begin
              state_n    = S_IDLE;
              brk_stop_n = 1'b0;
            end else begin
              tx_done = 1'b1;
              if (enable && !empty) launch = 1'b1;
              else state_n = S_IDLE;
            end
          end else begin
            tcnt_n = tcnt + ONE_T;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        out = 1'b0;
        if (brgen_tick) begin
          // Counter saturates at the minimum so a long-held brk simply waits here.
          if (tcnt == TW'({1'b0, nbits_q} + 5'd3) * BIT_T - ONE_T) begin
            if (!brk) begin
              state_n    = S_STOP;
              tcnt_n     = '0;
              brk_stop_n = 1'b1;
            end
          end else begin
            tcnt_n = tcnt + ONE_T;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      data_request = 1'b1;
      state_n      = S_START;
      tcnt_n       = '0;
      bit_cnt_n    = '0;
      shift_n      = data;
      nbits_n      = nbits_in;
      par_n        = parity;
      stop_n       = stop;
      par_bit_n    = par_bit_in;
      brk_stop_n   = 1'b0;
    end

    // A FIFO pop or completion pulse must never escape while reset is holding the engine.
    if (!reset) begin
      data_request = 1'b0;
      tx_done      = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      nbits_q    <= '0;
      par_q      <= '0;
      stop_q     <= '0;
      par_bit_q  <= 1'b0;
      brk_stop_q <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      nbits_q    <= nbits_n;
      par_q      <= par_n;
      stop_q     <= stop_n;
      par_bit_q  <= par_bit_n;
      brk_stop_q <= brk_stop_n;
    end
  end

endmodule
